// File: rtl/asm_pkg.sv
// Shared instruction-word layout and opcodes for the front-panel assembler.
package asm_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_JUMP = 4'h2;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 28;
  localparam int DEST_LSB = 26;
  localparam int SRC_LSB  = 24;
  localparam int VAL_LSB  = 0;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [1:0]  dest;
    logic [1:0]  src;
    logic [7:0]  rsvd;
    logic [15:0] value;
  } inst_t;

  // JUMP carries only a target, so its register fields are forced to zero.
  function automatic inst_t encode(input logic [3:0] op, input logic [1:0] dest,
                                   input logic [1:0] src, input logic [15:0] value);
    logic [31:0] w;
    w = '0;
    w[OPC_MSB:OPC_LSB] = op;
    if (op != OP_JUMP) begin
      w[DEST_LSB +: 2] = dest;
      w[SRC_LSB +: 2]  = src;
    end
    w[VAL_LSB +: 16] = value;
    return inst_t'(w);
  endfunction

endpackage

// File: rtl/assembler_if.sv
// Front-panel request inputs and program-memory write port of the assembler.
interface assembler_if #(parameter int ADDR_W = 8);
  logic              prog;
  logic [15:0]       value;
  logic [1:0]        dest;
  logic [1:0]        src;
  logic              asm_add;
  logic              asm_jump;
  logic [31:0]       inst;
  logic              store_clk;
  logic [ADDR_W-1:0] store_addr;
  logic              err;

  modport master (
    output prog, value, dest, src, asm_add, asm_jump,
    input  inst, store_clk, store_addr, err
  );

  modport slave (
    input  prog, value, dest, src, asm_add, asm_jump,
    output inst, store_clk, store_addr, err
  );
endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous level, plus a rising-edge pulse
// derived from the synchronised level.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign sync_d[gi] = din;
      end else begin : g_rest
        assign sync_d[gi] = sync_q[gi-1];
      end
    end
  endgenerate

  always_comb begin
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;

endmodule

// File: rtl/assembler.sv
// Turns synchronised front-panel ADD/JUMP button edges into instruction words,
// a one-cycle memory write strobe and an auto-incrementing write address.
module assembler
  import asm_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  assembler_if.slave  bus
);

  logic prog_s, prog_rise;
  logic add_s, add_rise;
  logic jump_s, jump_rise;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_prog (
    .clk(clk), .rst_n(rst_n), .din(bus.prog), .level(prog_s), .rise(prog_rise)
  );
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_add (
    .clk(clk), .rst_n(rst_n), .din(bus.asm_add), .level(add_s), .rise(add_rise)
  );
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_jump (
    .clk(clk), .rst_n(rst_n), .din(bus.asm_jump), .level(jump_s), .rise(jump_rise)
  );

  inst_t             inst_q, inst_d;
  logic              store_clk_q, store_clk_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              store_evt;
  logic [3:0]        op;

  always_comb begin
    op = OP_NOP;
    if (add_rise)       op = OP_ADD;
    else if (jump_rise) op = OP_JUMP;

    store_evt   = prog_s & (add_rise ^ jump_rise);
    inst_d      = inst_q;
    store_clk_d = store_evt;
    err_d       = prog_s & add_rise & jump_rise;
    addr_d      = addr_q;

    if (store_evt) inst_d = encode(op, bus.dest, bus.src, bus.value);

    // The address advances only after the strobe so it is stable while written.
    // Leaving program mode (or starting a fresh session) rewinds to 0.
    if (!prog_s || prog_rise) addr_d = '0;
    else if (store_clk_q)     addr_d = addr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q      <= '0;
      store_clk_q <= 1'b0;
      addr_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      inst_q      <= inst_d;
      store_clk_q <= store_clk_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
    end
  end

  // Synchronised request levels are only consumed through their edge pulses.
  logic unused_levels;
  assign unused_levels = add_s ^ jump_s;

  assign bus.inst       = inst_q;
  assign bus.store_clk  = store_clk_q;
  assign bus.store_addr = addr_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_assembler.sv
// Directed, table-driven check of the front-panel assembler (ADDR_W=2 so the
// address wrap is reachable), plus held-request and mid-strobe reset sequences.
module tb_assembler;
  localparam int AW = 2;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  assembler_if #(.ADDR_W(AW)) bus_if ();

  assembler #(.ADDR_W(AW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if)
  );

  typedef struct {
    logic          prog;
    logic          add;
    logic          jump;
    logic [15:0]   value;
    logic [1:0]    dest;
    logic [1:0]    src;
    int            exp_strobes;
    int            exp_errs;
    logic [31:0]   exp_inst;
    logic [AW-1:0] exp_addr_strobe;
    logic [AW-1:0] exp_addr_after;
  } vec_t;

  vec_t vecs[8];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int strobes, errs, lat;
    logic [31:0] inst_at;
    logic [AW-1:0] addr_at;
    strobes = 0; errs = 0; lat = -1; inst_at = '0; addr_at = '0;
    @(negedge clk);
    bus_if.prog = v.prog; bus_if.value = v.value; bus_if.dest = v.dest; bus_if.src = v.src;
    repeat (5) @(negedge clk);
    bus_if.asm_add = v.add; bus_if.asm_jump = v.jump;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (bus_if.store_clk === 1'b1) begin
        if (strobes == 0) begin
          lat = c; inst_at = bus_if.inst; addr_at = bus_if.store_addr;
        end
        strobes++;
      end
      if (bus_if.err === 1'b1) errs++;
      if (c == 4) begin
        bus_if.asm_add = 1'b0; bus_if.asm_jump = 1'b0;
      end
    end
    $display("vec %0d: prog=%0b add=%0b jump=%0b strobes=%0d errs=%0d lat=%0d inst=%h addr_at=%0d addr_after=%0d",
             idx, v.prog, v.add, v.jump, strobes, errs, lat, bus_if.inst, addr_at, bus_if.store_addr);
    check($sformatf("vec%0d strobes", idx), strobes, v.exp_strobes);
    check($sformatf("vec%0d errs", idx), errs, v.exp_errs);
    check($sformatf("vec%0d inst", idx), bus_if.inst, v.exp_inst);
    check($sformatf("vec%0d addr_after", idx), 32'(bus_if.store_addr), 32'(v.exp_addr_after));
    if (v.exp_strobes > 0) begin
      check($sformatf("vec%0d latency", idx), lat, SS + 1);
      check($sformatf("vec%0d inst_at_strobe", idx), inst_at, v.exp_inst);
      check($sformatf("vec%0d addr_at_strobe", idx), 32'(addr_at), 32'(v.exp_addr_strobe));
    end
  endtask

  initial begin
    int strobes;
    int waited;
    logic seen;

    //            prog add jump value     dest  src  str err inst          a@s   after
    vecs[0] = '{1'b1, 1'b1, 1'b0, 16'hABCD, 2'd2, 2'd1, 1, 0, 32'h1900_ABCD, 2'd0, 2'd1};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 16'hABCD, 2'd2, 2'd1, 1, 0, 32'h2000_ABCD, 2'd1, 2'd2};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 16'h5555, 2'd3, 2'd3, 0, 1, 32'h2000_ABCD, 2'd0, 2'd2};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h1234, 2'd3, 2'd0, 1, 0, 32'h1C00_1234, 2'd2, 2'd3};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 2'd3, 1, 0, 32'h1300_0000, 2'd3, 2'd0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 16'hFFFF, 2'd3, 2'd3, 1, 0, 32'h2000_FFFF, 2'd0, 2'd1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 16'h4321, 2'd1, 2'd1, 0, 0, 32'h2000_FFFF, 2'd0, 2'd0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 16'h0005, 2'd1, 2'd2, 1, 0, 32'h1600_0005, 2'd0, 2'd1};

    bus_if.prog = 1'b0; bus_if.value = '0; bus_if.dest = '0; bus_if.src = '0;
    bus_if.asm_add = 1'b0; bus_if.asm_jump = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: inst=%h store_clk=%0b addr=%0d err=%0b",
             bus_if.inst, bus_if.store_clk, bus_if.store_addr, bus_if.err);
    check("reset inst", bus_if.inst, 32'h0);
    check("reset store_clk", 32'(bus_if.store_clk), 32'd0);
    check("reset store_addr", 32'(bus_if.store_addr), 32'd0);
    check("reset err", 32'(bus_if.err), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Request already high when prog rises must not store.
    @(negedge clk);
    bus_if.prog = 1'b0;
    repeat (5) @(negedge clk);
    bus_if.asm_add = 1'b1;
    repeat (5) @(negedge clk);
    bus_if.prog = 1'b1;
    strobes = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus_if.store_clk === 1'b1) strobes++;
    end
    $display("held-before-prog: strobes=%0d inst=%h addr=%0d", strobes, bus_if.inst, bus_if.store_addr);
    check("held strobes", strobes, 0);
    check("held inst", bus_if.inst, 32'h1600_0005);
    check("held addr", 32'(bus_if.store_addr), 32'd0);
    bus_if.asm_add = 1'b0;
    repeat (4) @(negedge clk);

    // Reset asserted while the strobe is high clears outputs without a clock edge.
    bus_if.value = 16'h0F0F; bus_if.dest = 2'd1; bus_if.src = 2'd1;
    bus_if.asm_add = 1'b1;
    seen = 1'b0; waited = 0;
    while (!seen && waited < 10) begin
      @(posedge clk); #1;
      waited++;
      if (bus_if.store_clk === 1'b1) seen = 1'b1;
    end
    check("midreset strobe seen", 32'(seen), 32'd1);
    check("midreset inst before", bus_if.inst, 32'h1500_0F0F);
    #2 rst_n = 1'b0;
    #1;
    $display("mid-strobe reset: store_clk=%0b inst=%h addr=%0d err=%0b",
             bus_if.store_clk, bus_if.inst, bus_if.store_addr, bus_if.err);
    check("midreset store_clk", 32'(bus_if.store_clk), 32'd0);
    check("midreset inst", bus_if.inst, 32'h0);
    check("midreset addr", 32'(bus_if.store_addr), 32'd0);
    bus_if.asm_add = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
